// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, forwarding taps from EX/MEM and MEM/WB, and EX-side outputs.
// The stage uses the slave modport; whoever drives ID and the downstream stages uses master.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              flush_i;
   logic [DATA_W-1:0] id_rs_data_i;
   logic [DATA_W-1:0] id_rt_data_i;
   logic [DATA_W-1:0] id_imm_i;
   logic [REG_AW-1:0] id_rs_i;
   logic [REG_AW-1:0] id_rt_i;
   logic [REG_AW-1:0] id_rd_i;
   logic [3:0]        id_alu_ctrl_i;
   logic              id_alu_src_i;
   logic              id_reg_dst_i;
   logic              id_reg_write_i;
   logic              id_mem_read_i;
   logic              id_mem_write_i;
   logic              id_mem_to_reg_i;
   logic              exmem_reg_write_i;
   logic [REG_AW-1:0] exmem_rd_i;
   logic [DATA_W-1:0] exmem_result_i;
   logic              memwb_reg_write_i;
   logic [REG_AW-1:0] memwb_rd_i;
   logic [DATA_W-1:0] memwb_data_i;
   logic              stall_o;
   logic [DATA_W-1:0] alu_src1_o;
   logic [DATA_W-1:0] alu_src2_o;
   logic [3:0]        alu_ctrl_o;
   logic [DATA_W-1:0] store_data_o;
   logic [REG_AW-1:0] ex_dest_o;
   logic              ex_reg_write_o;
   logic              ex_mem_read_o;
   logic              ex_mem_write_o;
   logic              ex_mem_to_reg_o;

   modport master (
      output flush_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
             id_alu_ctrl_i, id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i,
             id_mem_write_i, id_mem_to_reg_i, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
             memwb_reg_write_i, memwb_rd_i, memwb_data_i,
      input  stall_o, alu_src1_o, alu_src2_o, alu_ctrl_o, store_data_o, ex_dest_o,
             ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o
   );

   modport slave (
      input  flush_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
             id_alu_ctrl_i, id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i,
             id_mem_write_i, id_mem_to_reg_i, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
             memwb_reg_write_i, memwb_rd_i, memwb_data_i,
      output stall_o, alu_src1_o, alu_src2_o, alu_ctrl_o, store_data_o, ex_dest_o,
             ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, bubble insertion and EX/MEM, MEM/WB operand forwarding.
// One cycle ID->EX; forwarding is combinational. A load-use hazard inserts exactly one bubble.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic          clk_i,
   input logic          rst_i,
   id_ex_stage_if.slave bus
);
   localparam logic [3:0] ALU_ADD = 4'b0010;

   typedef struct packed {
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [3:0]        alu_ctrl;
      logic              alu_src;
      logic              reg_dst;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
   } ex_regs_t;

   ex_regs_t          ex_q;
   ex_regs_t          ex_d;
   logic              hazard;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Load in EX whose target is read by the instruction in ID
   assign hazard = ex_q.mem_read && (ex_q.rt != '0) &&
                   ((ex_q.rt == bus.id_rs_i) || (ex_q.rt == bus.id_rt_i));

   always_comb begin
      ex_d          = '0;
      ex_d.alu_ctrl = ALU_ADD;
      if (!bus.flush_i && !hazard) begin
         ex_d.rs_data    = bus.id_rs_data_i;
         ex_d.rt_data    = bus.id_rt_data_i;
         ex_d.imm        = bus.id_imm_i;
         ex_d.rs         = bus.id_rs_i;
         ex_d.rt         = bus.id_rt_i;
         ex_d.rd         = bus.id_rd_i;
         ex_d.alu_ctrl   = bus.id_alu_ctrl_i;
         ex_d.alu_src    = bus.id_alu_src_i;
         ex_d.reg_dst    = bus.id_reg_dst_i;
         ex_d.reg_write  = bus.id_reg_write_i;
         ex_d.mem_read   = bus.id_mem_read_i;
         ex_d.mem_write  = bus.id_mem_write_i;
         ex_d.mem_to_reg = bus.id_mem_to_reg_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_q          <= '0;
         ex_q.alu_ctrl <= ALU_ADD;
      end else begin
         ex_q <= ex_d;
      end
   end

   // EX/MEM is younger than MEM/WB, so it wins; r0 is hardwired and never forwarded
   always_comb begin
      fwd_rs = ex_q.rs_data;
      if (bus.exmem_reg_write_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == ex_q.rs))
         fwd_rs = bus.exmem_result_i;
      else if (bus.memwb_reg_write_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == ex_q.rs))
         fwd_rs = bus.memwb_data_i;
   end

   always_comb begin
      fwd_rt = ex_q.rt_data;
      if (bus.exmem_reg_write_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == ex_q.rt))
         fwd_rt = bus.exmem_result_i;
      else if (bus.memwb_reg_write_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == ex_q.rt))
         fwd_rt = bus.memwb_data_i;
   end

   // A flush overrides the stall so the front end can redirect immediately
   assign bus.stall_o         = hazard && !bus.flush_i;
   assign bus.alu_src1_o      = fwd_rs;
   assign bus.alu_src2_o      = ex_q.alu_src ? ex_q.imm : fwd_rt;
   assign bus.store_data_o    = fwd_rt;
   assign bus.alu_ctrl_o      = ex_q.alu_ctrl;
   assign bus.ex_dest_o       = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
   assign bus.ex_reg_write_o  = ex_q.reg_write;
   assign bus.ex_mem_read_o   = ex_q.mem_read;
   assign bus.ex_mem_write_o  = ex_q.mem_write;
   assign bus.ex_mem_to_reg_o = ex_q.mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, r0, load-use bubble, immediates, flush, async reset.
module tb_id_ex_stage;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clr_fwd();
      bus.exmem_reg_write_i = 1'b0;
      bus.exmem_rd_i        = '0;
      bus.exmem_result_i    = '0;
      bus.memwb_reg_write_i = 1'b0;
      bus.memwb_rd_i        = '0;
      bus.memwb_data_i      = '0;
   endtask

   // Present one decoded instruction at the ID side
   task automatic id_set(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                         input logic [3:0] ctrl, input logic asrc, input logic rdst,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
      bus.id_rs_i         = rs;
      bus.id_rt_i         = rt;
      bus.id_rd_i         = rd;
      bus.id_rs_data_i    = rs_d;
      bus.id_rt_data_i    = rt_d;
      bus.id_imm_i        = imm;
      bus.id_alu_ctrl_i   = ctrl;
      bus.id_alu_src_i    = asrc;
      bus.id_reg_dst_i    = rdst;
      bus.id_reg_write_i  = rw;
      bus.id_mem_read_i   = mr;
      bus.id_mem_write_i  = mw;
      bus.id_mem_to_reg_i = m2r;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".rw"},  {31'd0, bus.ex_reg_write_o},  32'd0);
      chk({tag, ".mr"},  {31'd0, bus.ex_mem_read_o},   32'd0);
      chk({tag, ".mw"},  {31'd0, bus.ex_mem_write_o},  32'd0);
      chk({tag, ".m2r"}, {31'd0, bus.ex_mem_to_reg_o}, 32'd0);
      chk({tag, ".ctrl"}, {28'd0, bus.alu_ctrl_o},     32'h2);
      chk({tag, ".dest"}, {27'd0, bus.ex_dest_o},      32'd0);
   endtask

   initial begin
      // Reset with arbitrary noise on every input
      bus.flush_i = 1'b0;
      id_set(5'd7, 5'd9, 5'd11, 32'hAAAA5555, 32'h12345678, 32'hCAFEF00D, 4'b0111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      bus.exmem_reg_write_i = 1'b1; bus.exmem_rd_i = 5'd7; bus.exmem_result_i = 32'hBEEF;
      bus.memwb_reg_write_i = 1'b1; bus.memwb_rd_i = 5'd9; bus.memwb_data_i   = 32'hF00D;
      #2;
      tick();
      chk_bubble("rst");
      chk("rst.src1",  bus.alu_src1_o,   32'd0);
      chk("rst.src2",  bus.alu_src2_o,   32'd0);
      chk("rst.store", bus.store_data_o, 32'd0);
      chk("rst.stall", {31'd0, bus.stall_o}, 32'd0);

      // add r3,r1,r2 with r1=5, r2=7
      rst_i = 1'b1;
      clr_fwd();
      id_set(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("add.src1", bus.alu_src1_o, 32'd5);
      chk("add.src2", bus.alu_src2_o, 32'd7);
      chk("add.dest", {27'd0, bus.ex_dest_o}, 32'd3);
      chk("add.rw",   {31'd0, bus.ex_reg_write_o}, 32'd1);
      chk("add.ctrl", {28'd0, bus.alu_ctrl_o}, 32'h2);

      // Forwarding priority on rs=4
      id_set(5'd4, 5'd5, 5'd6, 32'h44, 32'h55, 32'd0, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.exmem_reg_write_i = 1'b1; bus.exmem_rd_i = 5'd4; bus.exmem_result_i = 32'h11;
      bus.memwb_reg_write_i = 1'b1; bus.memwb_rd_i = 5'd4; bus.memwb_data_i   = 32'h22;
      #1 chk("fwd.exmem", bus.alu_src1_o, 32'h11);
      chk("fwd.ctrl", {28'd0, bus.alu_ctrl_o}, 32'h6);
      bus.exmem_reg_write_i = 1'b0;
      #1 chk("fwd.memwb", bus.alu_src1_o, 32'h22);
      bus.memwb_reg_write_i = 1'b0;
      #1 chk("fwd.none", bus.alu_src1_o, 32'h44);

      // r0 is never forwarded
      clr_fwd();
      id_set(5'd0, 5'd5, 5'd6, 32'd0, 32'h55, 32'd0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.exmem_reg_write_i = 1'b1; bus.exmem_rd_i = 5'd0; bus.exmem_result_i = 32'hFFFF;
      bus.memwb_reg_write_i = 1'b1; bus.memwb_rd_i = 5'd0; bus.memwb_data_i   = 32'hEEEE;
      #1 chk("r0.src1", bus.alu_src1_o, 32'd0);
      clr_fwd();

      // Load-use: lw r8 in EX, add r11,r8,r10 in ID
      id_set(5'd9, 5'd8, 5'd0, 32'h100, 32'd0, 32'h4, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk("lw.dest", {27'd0, bus.ex_dest_o}, 32'd8);
      chk("lw.mr",   {31'd0, bus.ex_mem_read_o}, 32'd1);
      id_set(5'd8, 5'd10, 5'd11, 32'hDEAD, 32'h3, 32'd0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("lu.stall", {31'd0, bus.stall_o}, 32'd1);
      tick();
      chk_bubble("lu.bub");
      chk("lu.stall_clr", {31'd0, bus.stall_o}, 32'd0);
      tick();
      bus.memwb_reg_write_i = 1'b1; bus.memwb_rd_i = 5'd8; bus.memwb_data_i = 32'h1234;
      #1 chk("lu.src1", bus.alu_src1_o, 32'h1234);
      chk("lu.dest", {27'd0, bus.ex_dest_o}, 32'd11);
      clr_fwd();

      // addi with negative immediate
      id_set(5'd1, 5'd5, 5'd0, 32'd5, 32'd3, 32'hFFFFFFFC, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("addi.src2",  bus.alu_src2_o,   32'hFFFFFFFC);
      chk("addi.store", bus.store_data_o, 32'd3);
      chk("addi.dest",  {27'd0, bus.ex_dest_o}, 32'd5);

      // sw with rt forwarded from EX/MEM
      id_set(5'd2, 5'd6, 5'd0, 32'h40, 32'd0, 32'd4, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      bus.exmem_reg_write_i = 1'b1; bus.exmem_rd_i = 5'd6; bus.exmem_result_i = 32'd9;
      #1 chk("sw.store", bus.store_data_o, 32'd9);
      chk("sw.src2", bus.alu_src2_o, 32'd4);
      chk("sw.mw",   {31'd0, bus.ex_mem_write_o}, 32'd1);
      clr_fwd();

      // Flush together with load-use
      id_set(5'd1, 5'd12, 5'd0, 32'h0, 32'd0, 32'h8, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      id_set(5'd13, 5'd12, 5'd14, 32'h5, 32'h6, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("fl.stall_nofl", {31'd0, bus.stall_o}, 32'd1);
      bus.flush_i = 1'b1;
      #1 chk("fl.stall", {31'd0, bus.stall_o}, 32'd0);
      tick();
      bus.flush_i = 1'b0;
      chk_bubble("fl.bub");

      // Asynchronous reset between edges
      id_set(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ar.pre_rw", {31'd0, bus.ex_reg_write_o}, 32'd1);
      #2 rst_i = 1'b0;
      #1 chk_bubble("ar");
      chk("ar.src1", bus.alu_src1_o, 32'd0);
      rst_i = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
